// File: rtl/dna_hex_streamer.sv
// dna_hex_streamer
//   Streams a latched 57-bit device DNA word to a byte-wide UART transmitter
//   as 15 ASCII hex characters, most significant nibble first. The word is
//   zero-extended to 60 bits before conversion.
//
//   Build option: define DNA_CRLF_EN to append CR (0x0D) and LF (0x0A)
//   after the hex characters, making a stream 17 bytes instead of 15.
//
//   Parameters
//     UPPER     : 1 = hex letters emitted as 'A'-'F', 0 = 'a'-'f'
//   Ports
//     clk       : system clock, rising edge
//     rst_n     : asynchronous active-low reset
//     dna       : DNA word, MSB is the first bit shifted out of the device
//     dna_valid : level, dna is complete and stable
//     start     : single-cycle request to stream the current DNA
//     tx_data   : ASCII byte offered downstream
//     tx_valid  : tx_data valid; consumed when tx_valid & tx_ready
//     tx_ready  : downstream accepts a byte this cycle
//     busy      : high from accepted start until the last byte is consumed
//     done      : one-cycle pulse after the final byte handshake
module dna_hex_streamer #(
    parameter bit UPPER = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [56:0] dna,
    input  logic        dna_valid,
    input  logic        start,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        TERM,
        FIN
    } state_t;

    state_t      state_q, state_d;
    logic [56:0] dna_q, dna_d;
    logic [3:0]  cnt_q, cnt_d;

    logic [59:0] word_sh;
    logic [3:0]  nib;
    logic [7:0]  hex_char;

    // Shift the selected nibble up to the top of the 60-bit word so the
    // character counter indexes MSB-first without a variable part-select.
    always_comb begin
        word_sh = {3'b000, dna_q} << {cnt_q, 2'b00};
        nib     = word_sh[59:56];
        if (nib < 4'd10) begin
            hex_char = 8'h30 + {4'h0, nib};
        end else if (UPPER) begin
            hex_char = 8'h37 + {4'h0, nib};
        end else begin
            hex_char = 8'h57 + {4'h0, nib};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            dna_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            dna_q   <= dna_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        dna_d    = dna_q;
        cnt_d    = cnt_q;
        tx_data  = 8'h00;
        tx_valid = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;

        case (state_q)
            IDLE: begin
                if (start && dna_valid) begin
                    dna_d   = dna;
                    cnt_d   = '0;
                    state_d = SEND;
                end
            end

            SEND: begin
                busy     = 1'b1;
                tx_valid = 1'b1;
                tx_data  = hex_char;
                if (tx_ready) begin
                    if (cnt_q == 4'd14) begin
                        cnt_d = '0;
`ifdef DNA_CRLF_EN
                        state_d = TERM;
`else
                        state_d = FIN;
`endif
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end

`ifdef DNA_CRLF_EN
            // Counter bit 0 selects CR (0) then LF (1).
            TERM: begin
                busy     = 1'b1;
                tx_valid = 1'b1;
                tx_data  = cnt_q[0] ? 8'h0A : 8'h0D;
                if (tx_ready) begin
                    if (cnt_q[0]) begin
                        cnt_d   = '0;
                        state_d = FIN;
                    end else begin
                        cnt_d = 4'd1;
                    end
                end
            end
`endif

            FIN: begin
                done    = 1'b1;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: doc/dna_hex_streamer.md
DNA_HEX_STREAMER -- requirements
Module: dna_hex_streamer

Interface
REQ-001 Parameter: UPPER, 1, hex letters A-F emitted as uppercase ASCII (0x41-0x46) when 1 and lowercase (0x61-0x66) when 0.
REQ-002 clk  in  1  system clock; all sequential logic on posedge clk.
REQ-003 rst_n  in  1  reset; asynchronous, active-low.
REQ-004 dna  in  57  device DNA word from the DNA reader, MSB = first bit shifted out of the device.
REQ-005 dna_valid  in  1  level; high when dna is complete and stable.
REQ-006 start  in  1  single-cycle request to stream the current DNA.
REQ-007 tx_data  out  8  ASCII byte offered to the downstream UART transmitter.
REQ-008 tx_valid  out  1  tx_data is valid; byte is consumed on a cycle with tx_valid=1 and tx_ready=1.
REQ-009 tx_ready  in  1  downstream can accept a byte this cycle.
REQ-010 busy  out  1  high from the accepted start until the last byte is consumed.
REQ-011 done  out  1  one-cycle pulse after the final byte handshake.

Function
REQ-012 States: IDLE, SEND, TERM, FIN; reset state IDLE.
REQ-013 IDLE: start=1 with dna_valid=1 latches dna into an internal 57-bit copy, clears the 4-bit character counter, and moves to SEND next cycle; busy rises the same edge.
REQ-014 IDLE: start=1 with dna_valid=0 is ignored; no state change and no output.
REQ-015 The latched word is zero-extended to 60 bits ({3'b000, dna}) and emitted as 15 hex characters, most significant nibble first.
REQ-016 Nibble-to-ASCII: 0-9 map to 0x30-0x39; 10-15 map per UPPER.
REQ-017 SEND: tx_valid=1 and tx_data = character[counter]; tx_data and tx_valid SHALL hold stable until the handshake.
REQ-018 On each handshake the counter increments and the next character appears the following cycle; back-to-back handshakes with tx_ready held high SHALL yield one byte per cycle.
REQ-019 The handshake on character 14 leaves SEND: to TERM when DNA_CRLF_EN is defined, otherwise to FIN.
REQ-020 FIN: done=1 for exactly one cycle, busy=0, tx_valid=0, then IDLE.
REQ-021 start asserted while busy=1 is ignored and SHALL NOT restart or corrupt the stream.
REQ-022 dna or dna_valid changing during a stream has no effect; only the latched copy is emitted.
REQ-023 tx_valid SHALL NOT deassert without a handshake while in SEND or TERM.
REQ-024 tx_ready asserted while tx_valid=0 has no effect.

Reset
REQ-025 rst_n low asynchronously forces IDLE, tx_valid=0, tx_data=8'h00, busy=0, done=0, counter=0, and latched DNA=0.
REQ-026 Reset mid-stream aborts without a done pulse; after release the block waits for a new start.

Configuration
REQ-027 Macro DNA_CRLF_EN defined: TERM emits 0x0D, then 0x0A, each under the REQ-017 handshake rules, then FIN; a stream totals 17 bytes.
REQ-028 Macro DNA_CRLF_EN undefined: TERM is unreachable and may be omitted; a stream totals 15 bytes.

Verification
REQ-029 UPPER=1, no macro, dna=57'h123456789ABCDEF, dna_valid=1, start pulse, tx_ready=1 -> bytes "123456789ABCDEF" on 15 consecutive cycles, done pulse on the cycle after the 15th handshake.
REQ-030 UPPER=0, DNA_CRLF_EN defined, dna=57'h0AAAAAAAAAAAAAA -> "0aaaaaaaaaaaaaa" followed by 0x0D and 0x0A, 17 bytes total, then done.
REQ-031 tx_ready toggled pseudo-randomly (for example, 30% duty) -> tx_data is held stable while tx_valid=1 and tx_ready=0; the byte sequence matches REQ-029 with no drops and no duplicates.
REQ-032 start with dna_valid=0 -> busy and tx_valid stay 0 for 20 cycles; a second start during a stream, together with dna changed to 57'h1FFFFFFFFFFFFFF -> the stream still emits the originally latched value.
REQ-033 rst_n pulsed low after the 7th handshake -> all outputs go to their reset values immediately with no done pulse; a new start afterwards streams the full 15 bytes from character 0.
